// File: rtl/gpio_in_conditioner_if.sv
// Signal bundle between the raw pin conditioner and its consumer.
// The conditioner takes the slave side; a bench or upstream driver takes the master side.
interface gpio_in_conditioner_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] PINS;
  logic             DEBOUNCE_EN;
  logic             PARITYSEL;
  logic             PARERR_INJ;
  logic [WIDTH:0]   GPIOIN;
  logic             CHANGED;

  modport master (
    output PINS,
    output DEBOUNCE_EN,
    output PARITYSEL,
    output PARERR_INJ,
    input  GPIOIN,
    input  CHANGED
  );

  modport slave (
    input  PINS,
    input  DEBOUNCE_EN,
    input  PARITYSEL,
    input  PARERR_INJ,
    output GPIOIN,
    output CHANGED
  );
endinterface

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: per-pin synchroniser and debounce, followed by a registered
// data+parity word for the GPIO block and a one-cycle change pulse.
module gpio_in_conditioner #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic                HCLK,
  input  logic                HRESET,
  gpio_in_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] stable_reg;
  logic [WIDTH-1:0] stable_next;
  logic [CNT_W-1:0] cnt_reg  [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH:0]   gpioin_reg;
  logic             changed_reg;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int st = 0; st < SYNC_STAGES; st++) begin
        sync_reg[st] <= '0;
      end
    end else begin
      sync_reg[0] <= bus.PINS;
      for (int st = 1; st < SYNC_STAGES; st++) begin
        sync_reg[st] <= sync_reg[st-1];
      end
    end
  end

  assign sync_s = sync_reg[SYNC_STAGES-1];

  // Each pin qualifies independently; the counter only advances while the
  // synchronised level disagrees with the accepted level, so glitches clear it.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_debounce
      always_comb begin
        stable_next[gi] = stable_reg[gi];
        cnt_next[gi]    = '0;
        if (!bus.DEBOUNCE_EN) begin
          stable_next[gi] = sync_s[gi];
        end else if (sync_s[gi] != stable_reg[gi]) begin
          if (cnt_reg[gi] == CNT_MAX) begin
            stable_next[gi] = sync_s[gi];
          end else begin
            cnt_next[gi] = cnt_reg[gi] + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge HCLK) begin
        if (HRESET) begin
          cnt_reg[gi] <= '0;
        end else begin
          cnt_reg[gi] <= cnt_next[gi];
        end
      end
    end
  endgenerate

  // Parity is taken from the same stable value that loads the data bits, so
  // the word is always self-consistent.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      stable_reg  <= '0;
      gpioin_reg  <= '0;
      changed_reg <= 1'b0;
    end else begin
      stable_reg             <= stable_next;
      gpioin_reg[WIDTH-1:0]  <= stable_reg;
      gpioin_reg[WIDTH]      <= (^stable_reg) ^ bus.PARITYSEL ^ bus.PARERR_INJ;
      changed_reg            <= (stable_reg != gpioin_reg[WIDTH-1:0]);
    end
  end

  assign bus.GPIOIN  = gpioin_reg;
  assign bus.CHANGED = changed_reg;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner: expected GPIOIN/CHANGED per cycle are queued
// as stimulus is applied and popped one per clock.
module tb_gpio_in_conditioner;

  logic clk;
  logic rst;

  gpio_in_conditioner_if #(.WIDTH(16)) bus ();

  gpio_in_conditioner #(
    .WIDTH(16),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .HCLK(clk),
    .HRESET(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [16:0] gpio;
    logic        chg;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic push_n(input string tag, input logic [16:0] gpio, input logic chg, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.tag  = tag;
      e.gpio = gpio;
      e.chg  = chg;
      sb.push_back(e);
    end
  endtask

  task automatic run_n(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL sb_empty cycle=%0d observed=empty required=entry", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert (bus.GPIOIN === e.gpio) else begin
          failures++;
          $error("FAIL %s_gpioin cycle=%0d observed=%05h required=%05h", e.tag, cyc, bus.GPIOIN, e.gpio);
        end
        checks++;
        assert (bus.CHANGED === e.chg) else begin
          failures++;
          $error("FAIL %s_changed cycle=%0d observed=%0b required=%0b", e.tag, cyc, bus.CHANGED, e.chg);
        end
        $display("cycle=%0d %s pins=%04h gpioin=%05h changed=%0b", cyc, e.tag, bus.PINS, bus.GPIOIN, bus.CHANGED);
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.PINS        = 16'h0000;
    bus.DEBOUNCE_EN = 1'b1;
    bus.PARITYSEL   = 1'b1;
    bus.PARERR_INJ  = 1'b0;

    // 1: reset holds zero even with odd parity selected; first free edge loads parity
    push_n("reset", 17'h00000, 1'b0, 3);
    run_n(3);
    rst = 1'b0;
    push_n("par_first", 17'h10000, 1'b0, 3);
    run_n(3);

    // 2: single pin rise and fall through debounce, 7-edge latency
    bus.PARITYSEL = 1'b0;
    push_n("even_sel", 17'h00000, 1'b0, 1);
    run_n(1);
    bus.PINS = 16'h0001;
    push_n("rise0_wait", 17'h00000, 1'b0, 6);
    push_n("rise0_edge", 17'h10001, 1'b1, 1);
    push_n("rise0_hold", 17'h10001, 1'b0, 2);
    run_n(9);
    bus.PINS = 16'h0000;
    push_n("fall0_wait", 17'h10001, 1'b0, 6);
    push_n("fall0_edge", 17'h00000, 1'b1, 1);
    push_n("fall0_hold", 17'h00000, 1'b0, 2);
    run_n(9);

    // 3a: 3-cycle glitch on pin 3 is rejected
    bus.PINS = 16'h0008;
    push_n("glitch3", 17'h00000, 1'b0, 12);
    run_n(3);
    bus.PINS = 16'h0000;
    run_n(9);

    // 3b: 4-cycle pulse qualifies, release qualifies 4 cycles after reaching s
    bus.PINS = 16'h0008;
    push_n("pulse4_wait", 17'h00000, 1'b0, 6);
    push_n("pulse4_rise", 17'h10008, 1'b1, 1);
    push_n("pulse4_high", 17'h10008, 1'b0, 3);
    push_n("pulse4_fall", 17'h00000, 1'b1, 1);
    push_n("pulse4_low",  17'h00000, 1'b0, 2);
    run_n(4);
    bus.PINS = 16'h0000;
    run_n(9);

    // 4: bypass, multi-bit change in 4 edges, then parity-only change
    bus.DEBOUNCE_EN = 1'b0;
    bus.PINS        = 16'hA5A5;
    push_n("byp_wait", 17'h00000, 1'b0, 3);
    push_n("byp_edge", 17'h0A5A5, 1'b1, 1);
    push_n("byp_hold", 17'h0A5A5, 1'b0, 1);
    run_n(5);
    bus.PARITYSEL = 1'b1;
    push_n("odd_sel", 17'h1A5A5, 1'b0, 2);
    run_n(2);

    // 5: parity error injection
    bus.PARITYSEL  = 1'b0;
    bus.PARERR_INJ = 1'b1;
    bus.PINS       = 16'h0003;
    push_n("inj_old",  17'h1A5A5, 1'b0, 3);
    push_n("inj_edge", 17'h10003, 1'b1, 1);
    push_n("inj_hold", 17'h10003, 1'b0, 1);
    run_n(5);
    bus.PARERR_INJ = 1'b0;
    push_n("inj_off", 17'h00003, 1'b0, 2);
    run_n(2);

    // 6: reset while cnt[0]==2 discards progress; full latency afterwards
    bus.DEBOUNCE_EN = 1'b1;
    bus.PINS        = 16'h0000;
    push_n("clr_wait", 17'h00003, 1'b0, 6);
    push_n("clr_edge", 17'h00000, 1'b1, 1);
    push_n("clr_hold", 17'h00000, 1'b0, 1);
    run_n(8);
    bus.PINS = 16'h0001;
    push_n("midrst_cnt", 17'h00000, 1'b0, 4);
    run_n(4);
    rst = 1'b1;
    push_n("midrst_rst", 17'h00000, 1'b0, 1);
    run_n(1);
    rst = 1'b0;
    push_n("requal_wait", 17'h00000, 1'b0, 6);
    push_n("requal_edge", 17'h10001, 1'b1, 1);
    push_n("requal_hold", 17'h10001, 1'b0, 2);
    run_n(9);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_leftover observed=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
